seq_match_counter: RTL and testbench



---
 rtl/seq_match_counter_if.sv | 28 ++
 rtl/seq_match_counter.sv | 94 +++++++++
 tb/tb_seq_match_counter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seq_match_counter_if.sv
// Interface between the sequence-match counter and its stimulus and result side.
// The master side drives the serial samples and the start and result handshake.
// The slave side (the counter) returns its status and results.
interface seq_match_counter_if #(
  parameter int CW = 16,
  parameter int LW = 16
);
  logic          x_in;
  logic          z_in;
  logic          start;
  logic [LW-1:0] window_len;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] match_count;
  logic [CW-1:0] toggle_count;
  logic          ovf;

  modport master (
    output x_in, z_in, start, window_len, res_ready,
    input  busy, res_valid, match_count, toggle_count, ovf
  );

  modport slave (
    input  x_in, z_in, start, window_len, res_ready,
    output busy, res_valid, match_count, toggle_count, ovf
  );
endinterface

// File: rtl/seq_match_counter.sv
// seq_match_counter: counts "0110" detections (z_in) and serial-input toggles
// (x_in) over a programmable window, then offers both counts on a
// valid/ready handshake.
// Optional macro SEQ_MATCH_CNT_SAT_EN: counters saturate at all-ones instead
// of wrapping. ovf is set on the first increment past the maximum in both builds.
module seq_match_counter #(
  parameter int CW = 16,
  parameter int LW = 16
) (
  input logic             clk,
  input logic             rst,
  seq_match_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t        state, state_nxt;
  logic          x_prev;
  logic [LW-1:0] rem;
  logic [CW-1:0] m_cnt, t_cnt;
  logic          ovf_q;

  logic          acc_start;
  logic          toggle;
  logic [CW:0]   m_sum, t_sum;
  logic [CW-1:0] m_nxt, t_nxt;

  assign acc_start = bus.start && (bus.window_len != '0);
  assign toggle    = bus.x_in ^ x_prev;
  assign m_sum     = {1'b0, m_cnt} + {{CW{1'b0}}, bus.z_in};
  assign t_sum     = {1'b0, t_cnt} + {{CW{1'b0}}, toggle};

`ifdef SEQ_MATCH_CNT_SAT_EN
  // Carry out means the counter was already at max; pin it there.
  assign m_nxt = m_sum[CW] ? {CW{1'b1}} : m_sum[CW-1:0];
  assign t_nxt = t_sum[CW] ? {CW{1'b1}} : t_sum[CW-1:0];
`else
  // Plain modulo-2^CW wrap.
  assign m_nxt = m_sum[CW-1:0];
  assign t_nxt = t_sum[CW-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: a zero-length start is ignored, and so is start outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_start) state_nxt = COUNT;
      COUNT:   if (rem == LW'(1)) state_nxt = HOLD;
      HOLD:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: x history, remaining samples, counters and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev <= 1'b0;
      rem    <= '0;
      m_cnt  <= '0;
      t_cnt  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      x_prev <= bus.x_in;
      case (state)
        IDLE: if (acc_start) begin
          rem   <= bus.window_len;
          m_cnt <= '0;
          t_cnt <= '0;
          ovf_q <= 1'b0;
        end
        COUNT: begin
          rem   <= rem - LW'(1);
          m_cnt <= m_nxt;
          t_cnt <= t_nxt;
          if (m_sum[CW] || t_sum[CW]) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.res_valid    = (state == HOLD);
  assign bus.match_count  = m_cnt;
  assign bus.toggle_count = t_cnt;
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_seq_match_counter.sv
// Randomized self-checking bench for seq_match_counter. Runs with a narrow
// CW so that counter overflow is reachable within short windows.
module tb_seq_match_counter;
  localparam int CW  = 4;
  localparam int LW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   xv[64];
  bit   zv[64];

  always #5 clk = ~clk;

  seq_match_counter_if #(.CW(CW), .LW(LW)) bus ();
  seq_match_counter #(.CW(CW), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_vld"},  int'(bus.res_valid), 0);
  endtask

  // Sample list in xv/zv. Expected results are derived from the totals alone:
  // sums of z and of x changes, then wrapped or clamped to CW bits.
  task automatic run_window(input int len, input bit px, input int hold);
    int ms, ts, em, et, eo;
    bit prev;
    ms = 0; ts = 0; prev = px;
    bus.start = 1'b1; bus.window_len = LW'(len); bus.x_in = px; bus.z_in = 1'($urandom);
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      chk("cnt_busy", int'(bus.busy), 1);
      chk("cnt_vld", int'(bus.res_valid), 0);
      bus.x_in = xv[i]; bus.z_in = zv[i];
      bus.start = 1'($urandom); bus.window_len = LW'($urandom);
      ms += int'(zv[i]);
      ts += int'(xv[i] != prev);
      prev = xv[i];
      @(negedge clk);
    end
`ifdef SEQ_MATCH_CNT_SAT_EN
    em = (ms > MAX) ? MAX : ms;
    et = (ts > MAX) ? MAX : ts;
`else
    em = ms % (MAX + 1);
    et = ts % (MAX + 1);
`endif
    eo = int'(ms > MAX || ts > MAX);
    chk("res_vld", int'(bus.res_valid), 1);
    chk("match", int'(bus.match_count), em);
    chk("toggle", int'(bus.toggle_count), et);
    chk("ovf", int'(bus.ovf), eo);
    for (int h = 0; h < hold; h++) begin
      bus.res_ready = 1'b0; bus.start = 1'($urandom);
      bus.x_in = 1'($urandom); bus.z_in = 1'($urandom);
      @(negedge clk);
      chk("hold_vld", int'(bus.res_valid), 1);
      chk("hold_match", int'(bus.match_count), em);
      chk("hold_toggle", int'(bus.toggle_count), et);
      chk("hold_ovf", int'(bus.ovf), eo);
    end
    bus.res_ready = 1'b1; bus.start = 1'($urandom);
    @(negedge clk);
    bus.res_ready = 1'b0; bus.start = 1'b0;
    chk_idle("post_hs");
    chk("idle_match", int'(bus.match_count), em);
    chk("idle_toggle", int'(bus.toggle_count), et);
  endtask

  initial begin
    bus.x_in = 1'b0; bus.z_in = 1'b0; bus.start = 1'b0;
    bus.window_len = '0; bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then idle with toggling x.
    for (int i = 0; i < 4; i++) begin
      chk_idle("rst_idle");
      chk("rst_match", int'(bus.match_count), 0);
      chk("rst_toggle", int'(bus.toggle_count), 0);
      chk("rst_ovf", int'(bus.ovf), 0);
      bus.x_in = ~bus.x_in; bus.z_in = 1'($urandom);
      @(negedge clk);
    end

    // Basic window: x=0,1,1,0,1,1,0,0 after x=0, z on samples 4 and 7.
    {xv[0], xv[1], xv[2], xv[3], xv[4], xv[5], xv[6], xv[7]} = 8'b01101100;
    for (int i = 0; i < 8; i++) zv[i] = (i == 3 || i == 6);
    run_window(8, 1'b0, 5);

    // A zero-length start is ignored.
    bus.start = 1'b1; bus.window_len = '0;
    @(negedge clk);
    bus.start = 1'b0;
    chk_idle("zero_len");
    @(negedge clk);
    chk_idle("zero_len2");

    // Length-3 window with start pulses during COUNT.
    for (int i = 0; i < 3; i++) begin xv[i] = 1'($urandom); zv[i] = 1'($urandom); end
    run_window(3, 1'b1, 1);

    // Overflow: 20 samples, z=1 on every one.
    for (int i = 0; i < 20; i++) begin zv[i] = 1'b1; xv[i] = 1'($urandom); end
    run_window(20, 1'b0, 2);

    // Reset mid-window discards the partial result.
    bus.start = 1'b1; bus.window_len = LW'(10);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.x_in = 1'($urandom); bus.z_in = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("mid_rst");
    chk("mid_rst_match", int'(bus.match_count), 0);
    chk("mid_rst_ovf", int'(bus.ovf), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mid_rst_vld", int'(bus.res_valid), 0);
    end
    zv[0] = 1'b1; zv[1] = 1'b1; xv[0] = 1'b1; xv[1] = 1'b0;
    run_window(2, 1'b0, 0);

    // Length-1 window and random windows.
    xv[0] = 1'b1; zv[0] = 1'b1;
    run_window(1, 1'b1, 0);
    for (int w = 0; w < 10; w++) begin
      int len;
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) begin xv[i] = 1'($urandom); zv[i] = 1'($urandom); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_window(len, 1'($urandom), int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
